shape_table_ctrl: RTL and testbench
===================================

# shape_table_ctrl

Parametrised shape-table controller for the tangram renderer. Holds the attribute table for up to `MAXSHP` shapes and applies button edits once per frame to any selected shape. Supports magnitude-scaled steps and add/remove/select of shapes. After each edit it walks the table through an external trig/rotate datapath to refresh the per-shape `sin`/`cos`/`ix`/`iy` consumed by the render lanes.

## Interface
Parameters:
- `MAXSHP`, 8, table depth (≥2)
- `IDW`, `$clog2(MAXSHP)`, index width
- `INTW`, `INT_BITS`, integer attribute width
- `FLTW`, `FLOAT_BITS`, fixed-point width
- `PIXLW`, 12, colour width
- `SCR_W` / `SCR_H`, 800 / 600, screen bounds
- `MAX_SIZE`, 255, size ceiling
- `MAX_TYPE`, 3, last shape type
- `PREP_LAT`, 4, settle cycles per trig evaluation (≥1)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `endframe`  in  1  one-cycle end-of-frame pulse
- `mode`  in  2  0 move, 1 transform, 2 manage, 3 colour
- `btn_l/r/u/d/c`  in  1 each  repeat-qualified press
- `once_l/r/u/d/c`  in  1 each  single-shot press
- `mag`  in  2  step = 1<<mag
- `pick_color`  in  PIXLW  colour-picker output
- `prep_angle`, `prep_x0`, `prep_y0`  out  INTW  operands to trig/rotate
- `prep_sin`, `prep_cos`, `prep_ix`, `prep_iy`  in  FLTW  trig/rotate results
- `s_ty`, `s_x`, `s_y`, `s_size`  out  INTW×MAXSHP  shape attributes
- `s_angle`  out  signed INTW×MAXSHP  shape angle
- `s_color`  out  PIXLW×MAXSHP  shape colour
- `s_sin`, `s_cos`, `s_ix`, `s_iy`  out  FLTW×MAXSHP  precomputed values
- `active`  out  MAXSHP  live-shape mask
- `sel`  out  IDW  edited shape
- `count`  out  IDW+1  live shapes
- `done`  out  1  one-cycle pulse; clears button latches
- `table_valid`  out  1  set after the first complete walk
- `overrun`  out  1  sticky; an endframe was lost

## Operation
- States: INIT → WALK(PREP_W, PREP_I, PREP_R) → IDLE → EDIT → DONE → WALK.
- IDLE moves to EDIT on `endframe`.
- EDIT applies one update to entry `sel`. `l` has priority over `r`; `u` has priority over `d`.
  - Mode 0: x−/x+ and y−/y+ by step. Saturate to [0, SCR_W−1] and [0, SCR_H−1].
  - Mode 1:
    - l/r: angle ∓step. Wrap into [−180, 179] by ±360.
    - u/d: size ±step, saturated to [0, MAX_SIZE].
    - `once_c`: ty = (ty==MAX_TYPE) ? 0 : ty+1.
  - Mode 2:
    - `once_r` with count<MAXSHP: initialise entry `count` with defaults and set its `active` bit; count+1.
    - `once_l` with count>1: clear entry count−1 (colour 0, active 0); count−1. If sel was that entry, sel becomes count−2.
    - `once_c`: sel = (sel==count−1) ? 0 : sel+1.
  - Mode 3: `once_c` writes `pick_color` to colour[sel].
- Default entry values: x=SCR_W/2, y=SCR_H/2, size=32, angle=0, ty=0, colour 12'hFFF.
- WALK visits every entry 0..MAXSHP−1, inactive entries included:
  - PREP_W drives `prep_*` from the entry.
  - PREP_I waits PREP_LAT cycles.
  - PREP_R captures the four results into entry `a_id`.
- `endframe` outside IDLE sets a pending flag. On walk exit, go directly to EDIT if pending. A second `endframe` while pending sets `overrun`.
- Reset values:
  - count=1, sel=0, active=1, entry 0 = defaults.
  - All other entries 0.
  - All s_sin/cos/ix/iy = 0.
  - done=0, table_valid=0, overrun=0, pending=0.
  - State INIT.
- Reset mid-walk or mid-edit aborts the operation and restores reset values. The walk restarts from entry 0.

## Timing
- INIT: 1 cycle, then the walk.
- Walk: MAXSHP·(PREP_LAT+2) cycles. Defaults give 48.
- `endframe` at cycle t: EDIT at t+1, `done` at t+2, first PREP_W at t+3. `s_*` attributes update at t+2.
- Precomputed entry k updates at t+3+(k+1)(PREP_LAT+2)−1.
- `table_valid` rises the cycle after the last PREP_R of the first walk.
- All outputs are registered; no combinational input→output path except `prep_*`, which are decoded from registers.

## Structure
- `shape_pkg`:
  - mode enum
  - `shape_t` struct (ty, x, y, size, angle, colour)
  - default-entry constants
  - state enum
- Sub-module `bounded_step`: signed add of ±step with saturate or wrap selected by a port. Used for x, y, size and angle.

## Test plan
- Reset, then run to IDLE → count=1, sel=0, x0=400, y0=300, table_valid=1 after 1+48 cycles.
- Mode 0, mag=3, btn_l held, x0=4 → x0=0 after one frame and stays 0. Mode 0, mag=0, btn_d held with y0=599 → y0 stays 599.
- Mode 1, mag=2, angle=178, btn_r → angle=−178. btn_l and btn_r together → angle=174.
- Mode 2: once_r ×8 → count=8, active=8'hFF. Ninth once_r is ignored. With sel=7, once_l → count=7, sel=6, colour[7]=0.
- Mode 3, sel=2, pick_color=12'h0F0, once_c → s_color[2]=12'h0F0 at t+2; other entries unchanged.
- Two `endframe` pulses during one walk → one deferred EDIT and overrun=1. `rst` asserted mid-walk → reset values restored next cycle.

Source files
------------

// File: rtl/shape_pkg.sv
// Shared types and defaults for the shape-table controller: edit modes,
// controller states, the per-shape attribute record and its default value.
package shape_pkg;

  localparam int unsigned INT_BITS   = 16;
  localparam int unsigned FLOAT_BITS = 16;
  localparam int unsigned PIX_BITS   = 12;

  localparam int unsigned           DEF_SIZE  = 32;
  localparam logic [PIX_BITS-1:0]   DEF_COLOR = 12'hFFF;

  typedef enum logic [1:0] {
    MODE_MOVE   = 2'd0,
    MODE_XFORM  = 2'd1,
    MODE_MANAGE = 2'd2,
    MODE_COLOR  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_PREP_W,
    ST_PREP_I,
    ST_PREP_R,
    ST_IDLE,
    ST_EDIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        [INT_BITS-1:0] ty;
    logic        [INT_BITS-1:0] x;
    logic        [INT_BITS-1:0] y;
    logic        [INT_BITS-1:0] size;
    logic signed [INT_BITS-1:0] angle;
    logic        [PIX_BITS-1:0] colour;
  } shape_t;

  // Freshly added shapes start centred on screen, upright and white.
  function automatic shape_t default_shape(input int unsigned scr_w, input int unsigned scr_h);
    shape_t s;
    s.ty     = '0;
    s.x      = INT_BITS'(scr_w / 2);
    s.y      = INT_BITS'(scr_h / 2);
    s.size   = INT_BITS'(DEF_SIZE);
    s.angle  = '0;
    s.colour = DEF_COLOR;
    return s;
  endfunction

endpackage

// File: rtl/bounded_step.sv
// Signed add of +/-step to a value, then either saturate to [LO, HI] or wrap
// back into that range by its span (wrap selected per instance by a port).
module bounded_step
  import shape_pkg::*;
#(
  parameter int W  = INT_BITS,
  parameter int LO = 0,
  parameter int HI = 255
) (
  input  logic                en,
  input  logic                sub,
  input  logic                wrap,
  input  logic        [W-1:0] step,
  input  logic signed [W-1:0] val,
  output logic signed [W-1:0] res
);

  localparam int SPAN = HI - LO + 1;

  logic signed [W+1:0] ext_val;
  logic signed [W+1:0] ext_step;
  logic signed [W+1:0] sum;

  always_comb begin
    ext_val  = (W+2)'(val);
    ext_step = signed'({2'b00, step});
    sum      = sub ? (ext_val - ext_step) : (ext_val + ext_step);
    res      = val;
    if (en) begin
      // Steps never exceed one span, so a single correction is enough to wrap.
      if (sum > HI) begin
        res = wrap ? W'(sum - SPAN) : W'(HI);
      end else if (sum < LO) begin
        res = wrap ? W'(sum + SPAN) : W'(LO);
      end else begin
        res = W'(sum);
      end
    end
  end

endmodule

// File: rtl/shape_table_ctrl.sv
// Shape attribute table: applies one button edit per frame to the selected
// shape, then walks every entry through the external trig/rotate datapath.
module shape_table_ctrl
  import shape_pkg::*;
#(
  parameter int MAXSHP   = 8,
  parameter int IDW      = $clog2(MAXSHP),
  parameter int INTW     = INT_BITS,
  parameter int FLTW     = FLOAT_BITS,
  parameter int PIXLW    = 12,
  parameter int SCR_W    = 800,
  parameter int SCR_H    = 600,
  parameter int MAX_SIZE = 255,
  parameter int MAX_TYPE = 3,
  parameter int PREP_LAT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          endframe,
  input  logic [1:0]                    mode,
  input  logic                          btn_l,
  input  logic                          btn_r,
  input  logic                          btn_u,
  input  logic                          btn_d,
  input  logic                          btn_c,
  input  logic                          once_l,
  input  logic                          once_r,
  input  logic                          once_u,
  input  logic                          once_d,
  input  logic                          once_c,
  input  logic [1:0]                    mag,
  input  logic [PIXLW-1:0]              pick_color,
  output logic [INTW-1:0]               prep_angle,
  output logic [INTW-1:0]               prep_x0,
  output logic [INTW-1:0]               prep_y0,
  input  logic [FLTW-1:0]               prep_sin,
  input  logic [FLTW-1:0]               prep_cos,
  input  logic [FLTW-1:0]               prep_ix,
  input  logic [FLTW-1:0]               prep_iy,
  output logic [MAXSHP-1:0][INTW-1:0]   s_ty,
  output logic [MAXSHP-1:0][INTW-1:0]   s_x,
  output logic [MAXSHP-1:0][INTW-1:0]   s_y,
  output logic [MAXSHP-1:0][INTW-1:0]   s_size,
  output logic signed [MAXSHP-1:0][INTW-1:0] s_angle,
  output logic [MAXSHP-1:0][PIXLW-1:0]  s_color,
  output logic [MAXSHP-1:0][FLTW-1:0]   s_sin,
  output logic [MAXSHP-1:0][FLTW-1:0]   s_cos,
  output logic [MAXSHP-1:0][FLTW-1:0]   s_ix,
  output logic [MAXSHP-1:0][FLTW-1:0]   s_iy,
  output logic [MAXSHP-1:0]             active,
  output logic [IDW-1:0]                sel,
  output logic [IDW:0]                  count,
  output logic                          done,
  output logic                          table_valid,
  output logic                          overrun
);

  localparam int LATW = (PREP_LAT > 1) ? $clog2(PREP_LAT) : 1;
  localparam logic [LATW-1:0]     LAT_LAST = LATW'(PREP_LAT - 1);
  localparam logic [IDW-1:0]      LAST_ID  = IDW'(MAXSHP - 1);
  localparam logic [IDW:0]        CNT_MAX  = (IDW+1)'(MAXSHP);
  localparam logic [IDW:0]        CNT_ONE  = (IDW+1)'(1);
  localparam logic [INT_BITS-1:0] TY_LAST  = INT_BITS'(MAX_TYPE);

  state_e          state_q, state_d;
  shape_t          tbl_q [MAXSHP];
  shape_t          tbl_d [MAXSHP];
  logic [FLTW-1:0] sin_q [MAXSHP];
  logic [FLTW-1:0] sin_d [MAXSHP];
  logic [FLTW-1:0] cos_q [MAXSHP];
  logic [FLTW-1:0] cos_d [MAXSHP];
  logic [FLTW-1:0] ix_q  [MAXSHP];
  logic [FLTW-1:0] ix_d  [MAXSHP];
  logic [FLTW-1:0] iy_q  [MAXSHP];
  logic [FLTW-1:0] iy_d  [MAXSHP];
  logic [MAXSHP-1:0] active_q, active_d;
  logic [IDW-1:0]    sel_q, sel_d, a_id_q, a_id_d;
  logic [IDW:0]      count_q, count_d;
  logic [LATW-1:0]   lat_q, lat_d;
  logic done_q, done_d, valid_q, valid_d;
  logic overrun_q, overrun_d, pending_q, pending_d;

  mode_e                cur_mode;
  shape_t               cur;
  logic [IDW-1:0]       last_id;
  logic [INT_BITS-1:0]  step;
  logic signed [INT_BITS-1:0] new_x, new_y, new_size, new_angle;
  logic                 unused_btns;

  assign cur_mode    = mode_e'(mode);
  assign cur         = tbl_q[sel_q];
  assign last_id     = IDW'(count_q - CNT_ONE);
  assign step        = INT_BITS'(1) << mag;
  assign unused_btns = ^{btn_c, once_u, once_d};

  bounded_step #(.W(INT_BITS), .LO(0), .HI(SCR_W - 1)) u_step_x (
    .en(btn_l | btn_r), .sub(btn_l), .wrap(1'b0), .step(step),
    .val(signed'(cur.x)), .res(new_x)
  );

  bounded_step #(.W(INT_BITS), .LO(0), .HI(SCR_H - 1)) u_step_y (
    .en(btn_u | btn_d), .sub(btn_u), .wrap(1'b0), .step(step),
    .val(signed'(cur.y)), .res(new_y)
  );

  bounded_step #(.W(INT_BITS), .LO(0), .HI(MAX_SIZE)) u_step_size (
    .en(btn_u | btn_d), .sub(~btn_u), .wrap(1'b0), .step(step),
    .val(signed'(cur.size)), .res(new_size)
  );

  bounded_step #(.W(INT_BITS), .LO(-180), .HI(179)) u_step_angle (
    .en(btn_l | btn_r), .sub(btn_l), .wrap(1'b1), .step(step),
    .val(cur.angle), .res(new_angle)
  );

  always_comb begin
    state_d   = state_q;
    tbl_d     = tbl_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    ix_d      = ix_q;
    iy_d      = iy_q;
    active_d  = active_q;
    sel_d     = sel_q;
    count_d   = count_q;
    a_id_d    = a_id_q;
    lat_d     = lat_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    pending_d = pending_q;

    if (endframe && (state_q != ST_IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        a_id_d  = '0;
        state_d = ST_PREP_W;
      end
      ST_PREP_W: begin
        lat_d   = '0;
        state_d = ST_PREP_I;
      end
      ST_PREP_I: begin
        if (lat_q == LAT_LAST) state_d = ST_PREP_R;
        else                   lat_d   = lat_q + LATW'(1);
      end
      ST_PREP_R: begin
        sin_d[a_id_q] = prep_sin;
        cos_d[a_id_q] = prep_cos;
        ix_d[a_id_q]  = prep_ix;
        iy_d[a_id_q]  = prep_iy;
        if (a_id_q == LAST_ID) begin
          valid_d = 1'b1;
          a_id_d  = '0;
          // A frame that ended during the walk (even on this last cycle) is served now.
          if (pending_q || endframe) begin
            pending_d = 1'b0;
            state_d   = ST_EDIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          a_id_d  = a_id_q + IDW'(1);
          state_d = ST_PREP_W;
        end
      end
      ST_IDLE: begin
        if (endframe) state_d = ST_EDIT;
      end
      ST_EDIT: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
        case (cur_mode)
          MODE_MOVE: begin
            tbl_d[sel_q].x = new_x;
            tbl_d[sel_q].y = new_y;
          end
          MODE_XFORM: begin
            tbl_d[sel_q].angle = new_angle;
            tbl_d[sel_q].size  = new_size;
            if (once_c) tbl_d[sel_q].ty = (cur.ty == TY_LAST) ? '0 : cur.ty + INT_BITS'(1);
          end
          MODE_MANAGE: begin
            if (once_l && (count_q > CNT_ONE)) begin
              tbl_d[last_id].colour = '0;
              active_d[last_id]     = 1'b0;
              count_d               = count_q - CNT_ONE;
              if (sel_q == last_id) sel_d = IDW'(count_q - (IDW+1)'(2));
            end else if (once_r && (count_q < CNT_MAX)) begin
              tbl_d[count_q[IDW-1:0]]    = default_shape(SCR_W, SCR_H);
              active_d[count_q[IDW-1:0]] = 1'b1;
              count_d                    = count_q + CNT_ONE;
            end else if (once_c) begin
              sel_d = (sel_q == last_id) ? '0 : sel_q + IDW'(1);
            end
          end
          MODE_COLOR: begin
            if (once_c) tbl_d[sel_q].colour = PIX_BITS'(pick_color);
          end
        endcase
      end
      ST_DONE: begin
        a_id_d  = '0;
        state_d = ST_PREP_W;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      for (int unsigned i = 0; i < MAXSHP; i++) begin
        tbl_q[i] <= (i == 0) ? default_shape(SCR_W, SCR_H) : '0;
        sin_q[i] <= '0;
        cos_q[i] <= '0;
        ix_q[i]  <= '0;
        iy_q[i]  <= '0;
      end
      active_q  <= MAXSHP'(1);
      sel_q     <= '0;
      count_q   <= CNT_ONE;
      a_id_q    <= '0;
      lat_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tbl_q     <= tbl_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      ix_q      <= ix_d;
      iy_q      <= iy_d;
      active_q  <= active_d;
      sel_q     <= sel_d;
      count_q   <= count_d;
      a_id_q    <= a_id_d;
      lat_q     <= lat_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MAXSHP; i++) begin
      s_ty[i]    = INTW'(tbl_q[i].ty);
      s_x[i]     = INTW'(tbl_q[i].x);
      s_y[i]     = INTW'(tbl_q[i].y);
      s_size[i]  = INTW'(tbl_q[i].size);
      s_angle[i] = INTW'(tbl_q[i].angle);
      s_color[i] = PIXLW'(tbl_q[i].colour);
      s_sin[i]   = sin_q[i];
      s_cos[i]   = cos_q[i];
      s_ix[i]    = ix_q[i];
      s_iy[i]    = iy_q[i];
    end
  end

  assign prep_angle  = INTW'(tbl_q[a_id_q].angle);
  assign prep_x0     = INTW'(tbl_q[a_id_q].x);
  assign prep_y0     = INTW'(tbl_q[a_id_q].y);
  assign active      = active_q;
  assign sel         = sel_q;
  assign count       = count_q;
  assign done        = done_q;
  assign table_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_shape_table_ctrl.sv
// Bench for shape_table_ctrl: directed scenarios plus random frames, each
// checked against an integer-level model of the shape table.
module tb_shape_table_ctrl;

  localparam int MAXSHP = 8;
  localparam int LAT    = 4;
  localparam int WALK   = MAXSHP * (LAT + 2);

  localparam logic [9:0] BL = 10'h200, BR = 10'h100, BU = 10'h080, BD = 10'h040;
  localparam logic [9:0] BC = 10'h020, OL = 10'h010, K_OR = 10'h008, OC = 10'h001;

  logic clk = 1'b0;
  logic rst, endframe;
  logic [1:0] mode, mag;
  logic btn_l, btn_r, btn_u, btn_d, btn_c;
  logic once_l, once_r, once_u, once_d, once_c;
  logic [11:0] pick_color;
  logic [15:0] prep_angle, prep_x0, prep_y0;
  logic [15:0] prep_sin, prep_cos, prep_ix, prep_iy;
  logic [MAXSHP-1:0][15:0] s_ty, s_x, s_y, s_size, s_angle;
  logic [MAXSHP-1:0][11:0] s_color;
  logic [MAXSHP-1:0][15:0] s_sin, s_cos, s_ix, s_iy;
  logic [MAXSHP-1:0] active;
  logic [2:0] sel;
  logic [3:0] count;
  logic done, table_valid, overrun;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference table
  int m_ty[MAXSHP], m_x[MAXSHP], m_y[MAXSHP], m_size[MAXSHP], m_ang[MAXSHP], m_col[MAXSHP];
  bit m_act[MAXSHP];
  logic [15:0] m_sin[MAXSHP], m_cos[MAXSHP], m_ix[MAXSHP], m_iy[MAXSHP];
  int m_cnt, m_sel;

  always #5 clk = ~clk;

  shape_table_ctrl #(.MAXSHP(MAXSHP), .PREP_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .endframe(endframe), .mode(mode),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d), .btn_c(btn_c),
    .once_l(once_l), .once_r(once_r), .once_u(once_u), .once_d(once_d), .once_c(once_c),
    .mag(mag), .pick_color(pick_color),
    .prep_angle(prep_angle), .prep_x0(prep_x0), .prep_y0(prep_y0),
    .prep_sin(prep_sin), .prep_cos(prep_cos), .prep_ix(prep_ix), .prep_iy(prep_iy),
    .s_ty(s_ty), .s_x(s_x), .s_y(s_y), .s_size(s_size), .s_angle(s_angle), .s_color(s_color),
    .s_sin(s_sin), .s_cos(s_cos), .s_ix(s_ix), .s_iy(s_iy),
    .active(active), .sel(sel), .count(count), .done(done),
    .table_valid(table_valid), .overrun(overrun)
  );

  // Stand-in trig/rotate datapath: distinct deterministic function per result.
  function automatic logic [15:0] f_sin(input int a); return 16'(a * 3 + 17); endfunction
  function automatic logic [15:0] f_cos(input int a); return 16'(a) ^ 16'h5A5A; endfunction
  function automatic logic [15:0] f_ix(input int x, input int y); return 16'(x + 2 * y); endfunction
  function automatic logic [15:0] f_iy(input int x, input int y); return 16'(x - y + 1000); endfunction

  always_comb begin
    prep_sin = f_sin(int'($signed(prep_angle)));
    prep_cos = f_cos(int'($signed(prep_angle)));
    prep_ix  = f_ix(int'(prep_x0), int'(prep_y0));
    prep_iy  = f_iy(int'(prep_x0), int'(prep_y0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < MAXSHP; k++) begin
      m_ty[k] = 0; m_x[k] = 0; m_y[k] = 0; m_size[k] = 0; m_ang[k] = 0; m_col[k] = 0;
      m_act[k] = 0; m_sin[k] = '0; m_cos[k] = '0; m_ix[k] = '0; m_iy[k] = '0;
    end
    m_x[0] = 400; m_y[0] = 300; m_size[0] = 32; m_col[0] = 12'hFFF; m_act[0] = 1;
    m_cnt = 1; m_sel = 0;
  endfunction

  function automatic void model_walk();
    for (int k = 0; k < MAXSHP; k++) begin
      m_sin[k] = f_sin(m_ang[k]);
      m_cos[k] = f_cos(m_ang[k]);
      m_ix[k]  = f_ix(m_x[k], m_y[k]);
      m_iy[k]  = f_iy(m_x[k], m_y[k]);
    end
  endfunction

  function automatic void model_edit(input int md, input logic [9:0] b, input int mg, input int pc);
    int st;
    int s;
    st = 1 << mg;
    s  = m_sel;
    case (md)
      0: begin
        if (b[9])      m_x[s] = clamp(m_x[s] - st, 0, 799);
        else if (b[8]) m_x[s] = clamp(m_x[s] + st, 0, 799);
        if (b[7])      m_y[s] = clamp(m_y[s] - st, 0, 599);
        else if (b[6]) m_y[s] = clamp(m_y[s] + st, 0, 599);
      end
      1: begin
        if (b[9])      m_ang[s] -= st;
        else if (b[8]) m_ang[s] += st;
        if (m_ang[s] > 179)       m_ang[s] -= 360;
        else if (m_ang[s] < -180) m_ang[s] += 360;
        if (b[7])      m_size[s] = clamp(m_size[s] + st, 0, 255);
        else if (b[6]) m_size[s] = clamp(m_size[s] - st, 0, 255);
        if (b[0]) m_ty[s] = (m_ty[s] == 3) ? 0 : m_ty[s] + 1;
      end
      2: begin
        if (b[4] && m_cnt > 1) begin
          m_col[m_cnt-1] = 0;
          m_act[m_cnt-1] = 0;
          if (m_sel == m_cnt - 1) m_sel = m_cnt - 2;
          m_cnt--;
        end else if (b[3] && m_cnt < MAXSHP) begin
          m_x[m_cnt] = 400; m_y[m_cnt] = 300; m_size[m_cnt] = 32;
          m_ang[m_cnt] = 0; m_ty[m_cnt] = 0; m_col[m_cnt] = 12'hFFF; m_act[m_cnt] = 1;
          m_cnt++;
        end else if (b[0]) begin
          m_sel = (m_sel == m_cnt - 1) ? 0 : m_sel + 1;
        end
      end
      default: if (b[0]) m_col[s] = pc;
    endcase
  endfunction

  task automatic check_attrs(input string tag);
    logic [MAXSHP-1:0] act_exp;
    for (int k = 0; k < MAXSHP; k++) begin
      act_exp[k] = m_act[k];
      chk($sformatf("%s ty[%0d]", tag, k), s_ty[k], m_ty[k]);
      chk($sformatf("%s x[%0d]", tag, k), s_x[k], m_x[k]);
      chk($sformatf("%s y[%0d]", tag, k), s_y[k], m_y[k]);
      chk($sformatf("%s size[%0d]", tag, k), s_size[k], m_size[k]);
      chk($sformatf("%s angle[%0d]", tag, k), int'($signed(s_angle[k])), m_ang[k]);
      chk($sformatf("%s color[%0d]", tag, k), s_color[k], m_col[k]);
    end
    chk({tag, " active"}, active, act_exp);
    chk({tag, " count"}, count, m_cnt);
    chk({tag, " sel"}, sel, m_sel);
  endtask

  task automatic check_pre(input string tag);
    for (int k = 0; k < MAXSHP; k++) begin
      chk($sformatf("%s sin[%0d]", tag, k), s_sin[k], m_sin[k]);
      chk($sformatf("%s cos[%0d]", tag, k), s_cos[k], m_cos[k]);
      chk($sformatf("%s ix[%0d]", tag, k), s_ix[k], m_ix[k]);
      chk($sformatf("%s iy[%0d]", tag, k), s_iy[k], m_iy[k]);
    end
  endtask

  task automatic drive_btns(input logic [9:0] b);
    {btn_l, btn_r, btn_u, btn_d, btn_c, once_l, once_r, once_u, once_d, once_c} = b;
  endtask

  // Starts in IDLE, ends in IDLE after the refresh walk.
  task automatic run_frame(input int md, input logic [9:0] b, input int mg, input int pc, input bit full);
    mode = 2'(md); mag = 2'(mg); pick_color = 12'(pc);
    drive_btns(b);
    endframe = 1'b1;
    tick();                                   // t+1: EDIT
    endframe = 1'b0;
    if (full) chk("done_t1", done, 0);
    tick();                                   // t+2: DONE, attributes updated
    model_edit(md, b, mg, pc);
    chk("done_t2", done, 1);
    if (full) check_attrs("edit");
    drive_btns('0);
    repeat (WALK + 1) tick();                 // t+51: walk finished
    model_walk();
    if (full) check_pre("walk");
  endtask

  int done_pulses;

  initial begin
    rst = 1'b1; endframe = 1'b0; mode = '0; mag = '0; pick_color = '0;
    drive_btns('0);
    repeat (2) tick();
    model_reset();
    chk("rst count", count, 1);
    chk("rst sel", sel, 0);
    chk("rst active", active, 1);
    chk("rst x0", s_x[0], 400);
    chk("rst y0", s_y[0], 300);
    chk("rst color0", s_color[0], 12'hFFF);
    chk("rst x1", s_x[1], 0);
    chk("rst sin0", s_sin[0], 0);
    chk("rst valid", table_valid, 0);
    chk("rst done", done, 0);
    chk("rst overrun", overrun, 0);
    rst = 1'b0;
    repeat (WALK) tick();
    chk("valid_early", table_valid, 0);
    tick();
    chk("valid_first", table_valid, 1);
    model_walk();
    check_attrs("init");
    check_pre("init");

    // x saturates at 0 from 4 with step 8
    for (int i = 0; i < 49; i++) run_frame(0, BL, 3, 0, 0);
    chk("x0 ramp", s_x[0], 8);
    run_frame(0, BL, 2, 0, 1);
    chk("x0 four", s_x[0], 4);
    run_frame(0, BL, 3, 0, 1);
    chk("x0 sat", s_x[0], 0);
    run_frame(0, BL, 3, 0, 1);
    chk("x0 stay", s_x[0], 0);

    // y saturates at 599
    for (int i = 0; i < 37; i++) run_frame(0, BD, 3, 0, 0);
    for (int i = 0; i < 3; i++) run_frame(0, BD, 0, 0, 0);
    chk("y0 599", s_y[0], 599);
    run_frame(0, BD, 0, 0, 1);
    chk("y0 stay", s_y[0], 599);

    // angle wrap and l-over-r priority
    for (int i = 0; i < 22; i++) run_frame(1, BR, 3, 0, 0);
    run_frame(1, BR, 1, 0, 1);
    chk("ang 178", int'($signed(s_angle[0])), 178);
    run_frame(1, BR, 2, 0, 1);
    chk("ang wrap+", int'($signed(s_angle[0])), -178);
    run_frame(1, BL, 2, 0, 1);
    chk("ang wrap-", int'($signed(s_angle[0])), 178);
    run_frame(1, BL | BR, 2, 0, 1);
    chk("ang l_prio", int'($signed(s_angle[0])), 174);

    // add up to full table, then remove the selected last entry
    for (int i = 0; i < 7; i++) run_frame(2, K_OR, 0, 0, 1);
    chk("mgmt count8", count, 8);
    chk("mgmt activeFF", active, 8'hFF);
    run_frame(2, K_OR, 0, 0, 1);
    chk("mgmt full", count, 8);
    for (int i = 0; i < 7; i++) run_frame(2, OC, 0, 0, 0);
    chk("mgmt sel7", sel, 7);
    run_frame(2, OL, 0, 0, 1);
    chk("rm count", count, 7);
    chk("rm sel", sel, 6);
    chk("rm color7", s_color[7], 0);
    chk("rm active", active, 8'h7F);

    // colour pick on entry 2
    for (int i = 0; i < 3; i++) run_frame(2, OC, 0, 0, 1);
    chk("sel2", sel, 2);
    run_frame(3, OC, 0, 12'h0F0, 1);
    chk("color2", s_color[2], 12'h0F0);

    // two endframes during one walk: one deferred edit, overrun set
    mode = 2'd0; mag = 2'd0;
    endframe = 1'b1;
    tick();
    endframe = 1'b0;
    tick();                                   // t+2
    chk("ovr done", done, 1);
    model_edit(0, '0, 0, 0);
    repeat (3) tick();                        // t+5
    endframe = 1'b1;
    tick();
    endframe = 1'b0;
    chk("ovr first", overrun, 0);
    repeat (13) tick();                       // t+19
    endframe = 1'b1;
    drive_btns(BR);
    tick();                                   // t+20
    endframe = 1'b0;
    tick();
    chk("ovr second", overrun, 1);
    repeat (29) tick();                       // t+50
    chk("ovr no_done", done, 0);
    tick();                                   // t+51: deferred EDIT
    model_walk();
    check_pre("ovr walk");
    chk("ovr edit_done0", done, 0);
    tick();                                   // t+52: DONE
    chk("ovr deferred", done, 1);
    model_edit(0, BR, 0, 0);
    check_attrs("ovr edit");
    drive_btns('0);
    done_pulses = 0;
    for (int i = 0; i < WALK + 10; i++) begin
      tick();
      if (done) done_pulses++;
    end
    chk("ovr single_edit", done_pulses, 0);
    chk("ovr sticky", overrun, 1);
    model_walk();
    check_pre("ovr walk2");

    // reset in the middle of a walk
    mode = 2'd0; drive_btns(BR);
    endframe = 1'b1;
    tick();
    endframe = 1'b0;
    repeat (12) tick();
    drive_btns('0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_attrs("midrst");
    check_pre("midrst");
    chk("midrst valid", table_valid, 0);
    chk("midrst overrun", overrun, 0);
    chk("midrst done", done, 0);
    repeat (WALK + 1) tick();
    chk("midrst valid2", table_valid, 1);
    model_walk();
    check_pre("midrst walk");

    // random frames
    for (int i = 0; i < 40; i++) begin
      run_frame(int'($urandom_range(0, 3)), 10'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4095)), 1);
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("rand overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
